// File: rtl/pipe_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_arbiter
//  Purpose  : Round-robin arbiter feeding NREQ requesters into one shared
//             fixed-latency pipeline. It tags each issued word with its owner
//             and returns the pipeline output to that owner DELAY cycles later.
//             A drain handshake stops issue and reports when the pipe is empty.
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_arbiter #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8,
   parameter int DELAY = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*WIDTH-1:0] req_data,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ-1:0]       req_mask,
   input  logic                  drain,
   output logic [WIDTH-1:0]      pipe_in,
   output logic                  pipe_in_valid,
   input  logic [WIDTH-1:0]      pipe_out,
   output logic [NREQ-1:0]       rsp_valid,
   output logic [WIDTH-1:0]      rsp_data,
   output logic                  drained
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = $clog2(DELAY + 1);

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_DRAINING = 2'd1,
      ST_DRAINED  = 2'd2
   } state_t;

   state_t            r_state;
   logic              r_drained;
   logic [PW-1:0]     r_ptr;
   logic [CW-1:0]     r_inflight;
   logic [DELAY-1:0]  r_tv;
   logic [PW-1:0]     r_tidx [DELAY];

   logic [NREQ-1:0]   w_elig;
   logic [PW-1:0]     w_cand;
   logic [PW-1:0]     w_gnt_idx;
   logic              w_gnt_any;
   logic              w_can_issue;
   logic              w_grant;
   logic              w_retire;

   assign w_elig      = req_valid & req_mask;
   // Issue only in RUN, never in the cycle drain is seen, never during reset.
   assign w_can_issue = (r_state == ST_RUN) && !drain && !rst;
   assign w_grant     = w_gnt_any && w_can_issue;
   assign w_retire    = r_tv[DELAY-1];

   // Round-robin search: first eligible requester above ptr, wrapping to 0.
   always_comb begin
      w_gnt_any = 1'b0;
      w_gnt_idx = '0;
      w_cand    = '0;
      for (int off = 1; off <= NREQ; off++) begin
         w_cand = PW'((int'(r_ptr) + off) % NREQ);
         if (!w_gnt_any && w_elig[w_cand]) begin
            w_gnt_any = 1'b1;
            w_gnt_idx = w_cand;
         end
      end
   end

   assign req_ready     = w_grant ? (NREQ'(1) << w_gnt_idx) : '0;
   assign pipe_in_valid = w_grant;
   assign pipe_in       = w_grant ? req_data[w_gnt_idx*WIDTH +: WIDTH] : '0;

   // Responses: owner comes from the last tag stage, data straight from the pipe.
   assign rsp_valid = w_retire ? (NREQ'(1) << r_tidx[DELAY-1]) : '0;
   assign rsp_data  = pipe_out;
   assign drained   = r_drained;

   // Rotate the priority pointer to the last granted requester.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptr <= PW'(NREQ - 1);
      end else if (w_grant) begin
         r_ptr <= w_gnt_idx;
      end
   end

   // Owner tag shift register tracking words inside the external pipeline.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tv <= '0;
         for (int s = 0; s < DELAY; s++) begin
            r_tidx[s] <= '0;
         end
      end else begin
         r_tv[0]   <= w_grant;
         r_tidx[0] <= w_gnt_idx;
         for (int s = 1; s < DELAY; s++) begin
            r_tv[s]   <= r_tv[s-1];
            r_tidx[s] <= r_tidx[s-1];
         end
      end
   end

   // Count of words in flight; simultaneous issue and retire cancel out.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_inflight <= '0;
      end else if (w_grant && !w_retire) begin
         r_inflight <= r_inflight + CW'(1);
      end else if (!w_grant && w_retire) begin
         r_inflight <= r_inflight - CW'(1);
      end
   end

   // Drain control FSM with registered drained flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_RUN;
         r_drained <= 1'b0;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (drain) begin
                  r_state   <= ST_DRAINING;
                  r_drained <= 1'b0;
               end
            end
            ST_DRAINING: begin
               if (!drain) begin
                  r_state   <= ST_RUN;
                  r_drained <= 1'b0;
               end else if (r_inflight == '0) begin
                  r_state   <= ST_DRAINED;
                  r_drained <= 1'b1;
               end
            end
            ST_DRAINED: begin
               if (!drain) begin
                  r_state   <= ST_RUN;
                  r_drained <= 1'b0;
               end
            end
            default: begin
               r_state   <= ST_RUN;
               r_drained <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pipe_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_arbiter
//  Purpose  : Self-checking bench for pipe_arbiter (NREQ=4, WIDTH=8, DELAY=3).
//             Grant/drained expectations come from a vector table and short
//             hand sequences; response expectations come from a scoreboard
//             queue filled as each expected grant is driven.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_arbiter;

   localparam int NREQ  = 4;
   localparam int WIDTH = 8;
   localparam int DELAY = 3;

   logic                  clk;
   logic                  rst;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ*WIDTH-1:0] req_data;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ-1:0]       req_mask;
   logic                  drain;
   logic [WIDTH-1:0]      pipe_in;
   logic                  pipe_in_valid;
   logic [WIDTH-1:0]      pipe_out;
   logic [NREQ-1:0]       rsp_valid;
   logic [WIDTH-1:0]      rsp_data;
   logic                  drained;

   // External pipeline model: pipe_in delayed by DELAY cycles, never reset.
   logic [WIDTH-1:0] p0, p1, p2;
   always @(posedge clk) begin
      p0 <= pipe_in;
      p1 <= p0;
      p2 <= p1;
   end
   assign pipe_out = p2;

   pipe_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .DELAY(DELAY)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_data     (req_data),
      .req_ready    (req_ready),
      .req_mask     (req_mask),
      .drain        (drain),
      .pipe_in      (pipe_in),
      .pipe_in_valid(pipe_in_valid),
      .pipe_out     (pipe_out),
      .rsp_valid    (rsp_valid),
      .rsp_data     (rsp_data),
      .drained      (drained)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      int              due;
      logic [NREQ-1:0] owner;
      logic [WIDTH-1:0] data;
   } sb_t;

   typedef struct {
      logic [NREQ-1:0] v;
      logic [NREQ-1:0] m;
      logic            d;
      logic [NREQ-1:0] rdy;
      logic            dr;
   } vec_t;

   sb_t  sb [$];
   vec_t tbl [24];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
      end
   endtask

   // One clock cycle: drive at posedge+1, check at negedge, advance.
   task automatic apply(input logic [NREQ-1:0] v, input logic [NREQ-1:0] m,
                        input logic d, input logic [NREQ-1:0] exp_rdy, input logic exp_dr);
      logic [WIDTH-1:0] lane [NREQ];
      logic [WIDTH-1:0] exp_pin;
      sb_t              e;
      rst       = 1'b0;
      req_valid = v;
      req_mask  = m;
      drain     = d;
      exp_pin   = '0;
      for (int i = 0; i < NREQ; i++) begin
         lane[i] = 8'((cyc * 16 + i * 5 + 1) & 255);
         req_data[i*WIDTH +: WIDTH] = lane[i];
         if (exp_rdy[i]) exp_pin = lane[i];
      end
      #4;
      chk("req_ready",     32'(req_ready),     32'(exp_rdy));
      chk("drained",       32'(drained),       32'(exp_dr));
      chk("pipe_in_valid", 32'(pipe_in_valid), 32'(|exp_rdy));
      chk("pipe_in",       32'(pipe_in),       32'(exp_pin));
      if (sb.size() > 0 && sb[0].due == cyc) begin
         e = sb.pop_front();
         chk("rsp_valid", 32'(rsp_valid), 32'(e.owner));
         chk("rsp_data",  32'(rsp_data),  32'(e.data));
      end else begin
         chk("rsp_valid_idle", 32'(rsp_valid), 32'd0);
      end
      if (exp_rdy != '0) sb.push_back('{cyc + DELAY, exp_rdy, exp_pin});
      cyc++;
      @(posedge clk);
      #1;
   endtask

   // Reset cycle with requests pending: every output must read zero.
   task automatic reset_cycle();
      rst       = 1'b1;
      req_valid = '1;
      req_mask  = '1;
      drain     = 1'b0;
      #4;
      chk("rst_req_ready",     32'(req_ready),     32'd0);
      chk("rst_pipe_in_valid", 32'(pipe_in_valid), 32'd0);
      chk("rst_pipe_in",       32'(pipe_in),       32'd0);
      chk("rst_rsp_valid",     32'(rsp_valid),     32'd0);
      chk("rst_drained",       32'(drained),       32'd0);
      sb.delete();
      cyc++;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d actual=timeout expected=finish", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      // Arbitration vectors: {valid, mask, drain, expected ready, expected drained}
      tbl[0]  = '{4'b1111, 4'b1111, 1'b0, 4'b0001, 1'b0};
      tbl[1]  = '{4'b1111, 4'b1111, 1'b0, 4'b0010, 1'b0};
      tbl[2]  = '{4'b1111, 4'b1111, 1'b0, 4'b0100, 1'b0};
      tbl[3]  = '{4'b1111, 4'b1111, 1'b0, 4'b1000, 1'b0};
      tbl[4]  = '{4'b1111, 4'b1111, 1'b0, 4'b0001, 1'b0};
      tbl[5]  = '{4'b1111, 4'b1010, 1'b0, 4'b0010, 1'b0};
      tbl[6]  = '{4'b1111, 4'b1010, 1'b0, 4'b1000, 1'b0};
      tbl[7]  = '{4'b1111, 4'b1010, 1'b0, 4'b0010, 1'b0};
      tbl[8]  = '{4'b1111, 4'b1010, 1'b0, 4'b1000, 1'b0};
      tbl[9]  = '{4'b0100, 4'b1111, 1'b0, 4'b0100, 1'b0};
      tbl[10] = '{4'b0100, 4'b1111, 1'b0, 4'b0100, 1'b0};
      tbl[11] = '{4'b0100, 4'b1111, 1'b0, 4'b0100, 1'b0};
      tbl[12] = '{4'b0100, 4'b1111, 1'b0, 4'b0100, 1'b0};
      tbl[13] = '{4'b0000, 4'b1111, 1'b0, 4'b0000, 1'b0};
      tbl[14] = '{4'b0000, 4'b1111, 1'b0, 4'b0000, 1'b0};
      tbl[15] = '{4'b0000, 4'b1111, 1'b0, 4'b0000, 1'b0};
      tbl[16] = '{4'b0011, 4'b1111, 1'b0, 4'b0001, 1'b0};
      tbl[17] = '{4'b0011, 4'b1101, 1'b0, 4'b0001, 1'b0};
      tbl[18] = '{4'b0011, 4'b1111, 1'b0, 4'b0010, 1'b0};
      tbl[19] = '{4'b1111, 4'b0000, 1'b0, 4'b0000, 1'b0};
      tbl[20] = '{4'b1111, 4'b1111, 1'b0, 4'b0100, 1'b0};
      tbl[21] = '{4'b0000, 4'b1111, 1'b0, 4'b0000, 1'b0};
      tbl[22] = '{4'b0000, 4'b1111, 1'b0, 4'b0000, 1'b0};
      tbl[23] = '{4'b0000, 4'b1111, 1'b0, 4'b0000, 1'b0};

      rst       = 1'b1;
      req_valid = '0;
      req_mask  = '0;
      req_data  = '0;
      drain     = 1'b0;
      @(posedge clk);
      #1;
      reset_cycle();

      for (int k = 0; k < 24; k++) begin
         apply(tbl[k].v, tbl[k].m, tbl[k].d, tbl[k].rdy, tbl[k].dr);
      end

      // Drain with three words in flight, then release and resume after ptr.
      apply(4'b1111, 4'b1111, 1'b0, 4'b1000, 1'b0);
      apply(4'b1111, 4'b1111, 1'b0, 4'b0001, 1'b0);
      apply(4'b1111, 4'b1111, 1'b0, 4'b0010, 1'b0);
      apply(4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b0);
      apply(4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b0);
      apply(4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b0);
      apply(4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b0);
      apply(4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b1);
      apply(4'b1111, 4'b1111, 1'b0, 4'b0000, 1'b1);
      apply(4'b1111, 4'b1111, 1'b0, 4'b0100, 1'b0);
      apply(4'b0000, 4'b1111, 1'b0, 4'b0000, 1'b0);
      apply(4'b0000, 4'b1111, 1'b0, 4'b0000, 1'b0);
      apply(4'b0000, 4'b1111, 1'b0, 4'b0000, 1'b0);

      // Drain with an empty pipe, then drain dropped before empty; the
      // final grant to 0 coincides with requester 0's own response.
      apply(4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b0);
      apply(4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b0);
      apply(4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b1);
      apply(4'b0001, 4'b1111, 1'b0, 4'b0000, 1'b1);
      apply(4'b0001, 4'b1111, 1'b0, 4'b0001, 1'b0);
      apply(4'b0001, 4'b1111, 1'b1, 4'b0000, 1'b0);
      apply(4'b0001, 4'b1111, 1'b0, 4'b0000, 1'b0);
      apply(4'b0001, 4'b1111, 1'b0, 4'b0001, 1'b0);
      apply(4'b0000, 4'b1111, 1'b0, 4'b0000, 1'b0);
      apply(4'b0000, 4'b1111, 1'b0, 4'b0000, 1'b0);
      apply(4'b0000, 4'b1111, 1'b0, 4'b0000, 1'b0);

      // Reset with two words in flight: they must never come back.
      apply(4'b1111, 4'b1111, 1'b0, 4'b0010, 1'b0);
      apply(4'b1111, 4'b1111, 1'b0, 4'b0100, 1'b0);
      reset_cycle();
      apply(4'b0000, 4'b1111, 1'b0, 4'b0000, 1'b0);
      apply(4'b0000, 4'b1111, 1'b0, 4'b0000, 1'b0);
      apply(4'b1000, 4'b1111, 1'b0, 4'b1000, 1'b0);
      apply(4'b0000, 4'b1111, 1'b0, 4'b0000, 1'b0);
      apply(4'b0000, 4'b1111, 1'b0, 4'b0000, 1'b0);
      apply(4'b0000, 4'b1111, 1'b0, 4'b0000, 1'b0);

      chk("scoreboard_empty", 32'(sb.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pipe_arbiter.md
PIPE_ARBITER -- requirements
Module: pipe_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing one fixed-latency pipeline (2..8).
REQ-002 Parameter WIDTH, default 8, data width of each requester word.
REQ-003 Parameter DELAY, default 3, latency in cycles of the external pipeline being shared (1..16).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 req_valid  input  NREQ  per-requester word-available flag.
REQ-007 req_data  input  NREQ*WIDTH  per-requester word; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-008 req_ready  output  NREQ  one-hot grant; the word of requester i is consumed in any cycle where req_valid[i] and req_ready[i] are both high.
REQ-009 req_mask  input  NREQ  static enable; requester i is never granted while req_mask[i]=0.
REQ-010 drain  input  1  level request to stop issuing and empty the pipeline.
REQ-011 pipe_in  output  WIDTH  word driven into the external pipeline; equals req_data of the granted requester, else 0.
REQ-012 pipe_in_valid  output  1  high in cycles where a word is issued into the pipeline.
REQ-013 pipe_out  input  WIDTH  external pipeline output, equal to pipe_in delayed by exactly DELAY cycles.
REQ-014 rsp_valid  output  NREQ  one-hot return strobe identifying the owner of pipe_out.
REQ-015 rsp_data  output  WIDTH  pipe_out passed through combinationally.
REQ-016 drained  output  1  high when the block is in state DRAINED.

Function
REQ-017 Arbitration SHALL be combinational round-robin over eligible requesters (req_valid & req_mask), searching upward from index ptr+1 with wrap to 0.
REQ-018 At most one req_ready bit SHALL be high per cycle, and only when state is RUN.
REQ-019 After each grant to requester g, ptr SHALL update to g on the next edge; ptr SHALL hold in cycles with no grant.
REQ-020 The block SHALL keep an internal DELAY-stage shift register of {valid, owner index}; stage 0 loads {pipe_in_valid, grant index} each cycle.
REQ-021 rsp_valid[k] SHALL be high exactly DELAY cycles after the cycle requester k was granted, and low otherwise.
REQ-022 No backpressure SHALL exist on the response side; responses are never dropped or reordered.
REQ-023 inflight, a counter of width clog2(DELAY+1), SHALL increment on issue, decrement on a valid tag leaving the last stage, hold when both occur in the same cycle, and never exceed DELAY.
REQ-024 FSM states: RUN, DRAINING, DRAINED.
REQ-025 RUN -> DRAINING when drain=1; no grant is issued in the cycle drain is first sampled high.
REQ-026 DRAINING -> DRAINED when inflight=0, including the case where inflight is already 0 on entry (one cycle in DRAINING).
REQ-027 DRAINED -> RUN when drain=0; DRAINING -> RUN when drain drops before empty; in-flight tags continue to retire normally in all states.
REQ-028 A change of req_mask SHALL take effect in the same cycle; masking does not cancel in-flight words.
REQ-029 Simultaneous issue and retire on the same requester in one cycle SHALL both be honoured.

Reset
REQ-030 While rst=1: state=RUN, ptr=NREQ-1 (first search starts at 0), all tag stages invalid, inflight=0, req_ready=0, pipe_in_valid=0, pipe_in=0, rsp_valid=0, drained=0.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight tags; pipe_out words arriving after reset release produce no rsp_valid.

Verification
REQ-032 Reset, then req_valid=4'b1111 held, mask=4'b1111 -> grants 0,1,2,3,0 on successive cycles; rsp_valid=0001 first at cycle 3 after first grant (DELAY=3).
REQ-033 req_valid=4'b0100 only -> requester 2 granted every cycle; rsp_valid=0100 continuous after 3 cycles; rsp_data equals issued words in order.
REQ-034 req_valid=4'b1111, mask=4'b1010 -> grants alternate 1,3,1,3; bits 0 and 2 never ready.
REQ-035 Three words in flight, assert drain -> no further grants; drained rises in the cycle after inflight reaches 0; drop drain -> state RUN and grants resume from ptr+1 on the next cycle.
REQ-036 Assert rst with 2 words in flight -> outputs zero immediately; after release, zero rsp_valid pulses for those words; next request granted normally.
REQ-037 Drain with pipeline already empty -> drained high two cycles after drain sampled (RUN->DRAINING->DRAINED).
